// File: rtl/pipe_if_ctrl_if.sv
// pipe_if_ctrl_if
//   Bundles the fetch-stage control signals exchanged between the IF
//   pipeline controller and the surrounding datapath.
//
//   master : the controller (drives PC / IF/ID / ID/EX controls, status)
//   slave  : the datapath side (drives imem status, hazard and branch info)
//
//   Signals:
//     imem_valid_s1    instruction memory data valid for current PC
//     branch_taken_s2  ID stage resolved a taken branch or jump
//     ex_mem_read      instruction in EX is a load
//     ex_rt            load destination register in EX
//     id_rs, id_rt     source registers of the instruction in ID
//     id_uses_rt       ID instruction reads rt
//     pc_en            PC register load enable
//     pc_sel_target    PC loads branch/jump target instead of PC+4
//     load_instr_s1    IF/ID register capture enable
//     flush_s1         IF/ID captures a NOP instead of memory data
//     bubble_s2        ID/EX captures a NOP
//     id_valid_s1      registered IF/ID valid bit
//     state_s1         FSM state (FILL=0 RUN=1 WAIT=2 STALL=3 FLUSH=4)
//     stall_cnt, flush_cnt, wait_cnt  saturating event counters
//     imem_err         sticky fetch-timeout flag
interface pipe_if_ctrl_if #(
    parameter int ADDR_LEFT = 4,
    parameter int CNT_BITS  = 16
);
    logic                 imem_valid_s1;
    logic                 branch_taken_s2;
    logic                 ex_mem_read;
    logic [ADDR_LEFT:0]   ex_rt;
    logic [ADDR_LEFT:0]   id_rs;
    logic [ADDR_LEFT:0]   id_rt;
    logic                 id_uses_rt;

    logic                 pc_en;
    logic                 pc_sel_target;
    logic                 load_instr_s1;
    logic                 flush_s1;
    logic                 bubble_s2;
    logic                 id_valid_s1;
    logic [2:0]           state_s1;
    logic [CNT_BITS-1:0]  stall_cnt;
    logic [CNT_BITS-1:0]  flush_cnt;
    logic [CNT_BITS-1:0]  wait_cnt;
    logic                 imem_err;

    modport master (
        input  imem_valid_s1, branch_taken_s2, ex_mem_read,
               ex_rt, id_rs, id_rt, id_uses_rt,
        output pc_en, pc_sel_target, load_instr_s1, flush_s1, bubble_s2,
               id_valid_s1, state_s1, stall_cnt, flush_cnt, wait_cnt,
               imem_err
    );

    modport slave (
        output imem_valid_s1, branch_taken_s2, ex_mem_read,
               ex_rt, id_rs, id_rt, id_uses_rt,
        input  pc_en, pc_sel_target, load_instr_s1, flush_s1, bubble_s2,
               id_valid_s1, state_s1, stall_cnt, flush_cnt, wait_cnt,
               imem_err
    );
endinterface

// File: rtl/pipe_if_ctrl.sv
// pipe_if_ctrl
//   Fetch-stage pipeline controller. Each cycle picks one action -- fill,
//   stall on load-use, flush on taken branch, wait on imem, or advance --
//   and drives the PC, IF/ID and ID/EX controls accordingly. Owns the IF/ID
//   valid bit, saturating event counters and a fetch-timeout watchdog.
//
//   Ports:
//     i clk   clock, rising edge
//     i rst_  synchronous reset, active-high
//     bus     pipe_if_ctrl_if.master (all control / status signals)
module pipe_if_ctrl #(
    parameter int BITS      = 32,
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
    parameter int CNT_BITS  = 16,
    parameter int TIMEOUT   = 255
) (
    input logic            clk,
    input logic            rst_,
    pipe_if_ctrl_if.master bus
);

    if (BITS < 1 || TIMEOUT < 1 || CNT_BITS < 1) begin : g_bad_param
        $error("pipe_if_ctrl: BITS, TIMEOUT and CNT_BITS must be >= 1");
    end

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STALL = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ACT_FILL,
        ACT_STALL,
        ACT_FLUSH,
        ACT_WAIT,
        ACT_RUN
    } act_t;

    state_t              r_state;
    logic                r_id_valid;
    logic [CNT_BITS-1:0] r_stall_cnt;
    logic [CNT_BITS-1:0] r_flush_cnt;
    logic [CNT_BITS-1:0] r_wait_cnt;
    logic [WD_W-1:0]     r_wd;
    logic                r_imem_err;

    logic   w_hazard;
    logic   w_br;
    act_t   w_act;
    state_t w_next_state;

    // Load-use: register 0 is hard-wired, so a load to it never conflicts.
    assign w_hazard = bus.ex_mem_read && r_id_valid && (bus.ex_rt != '0) &&
                      ((bus.ex_rt == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    assign w_br     = bus.branch_taken_s2 && r_id_valid;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_act             = ACT_RUN;
        w_next_state      = ST_RUN;
        bus.pc_en         = 1'b1;
        bus.pc_sel_target = 1'b0;
        bus.load_instr_s1 = 1'b1;
        bus.flush_s1      = 1'b0;
        bus.bubble_s2     = 1'b0;

        // Reset forces FILL outputs even before the state register settles.
        if (rst_ || r_state == ST_FILL) begin
            w_act         = ACT_FILL;
            bus.pc_en     = 1'b0;
            bus.flush_s1  = 1'b1;
            bus.bubble_s2 = 1'b1;
        end else if (w_hazard) begin
            // Hazard outranks a branch: the branch re-resolves next cycle
            // once the load data can be forwarded.
            w_act             = ACT_STALL;
            w_next_state      = ST_STALL;
            bus.pc_en         = 1'b0;
            bus.load_instr_s1 = 1'b0;
            bus.bubble_s2     = 1'b1;
        end else if (w_br) begin
            // Redirect wins over a missing fetch so the target is never lost.
            w_act             = ACT_FLUSH;
            w_next_state      = ST_FLUSH;
            bus.pc_sel_target = 1'b1;
            bus.flush_s1      = 1'b1;
        end else if (!bus.imem_valid_s1) begin
            w_act        = ACT_WAIT;
            w_next_state = ST_WAIT;
            bus.pc_en    = 1'b0;
            bus.flush_s1 = 1'b1;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state     <= ST_FILL;
            r_id_valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
            r_wd        <= '0;
            r_imem_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            unique case (w_act)
                ACT_STALL: r_id_valid <= r_id_valid;
                ACT_RUN:   r_id_valid <= 1'b1;
                default:   r_id_valid <= 1'b0;
            endcase

            if (w_act == ACT_STALL && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_act == ACT_FLUSH && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_act == ACT_WAIT && r_wait_cnt != '1)
                r_wait_cnt <= r_wait_cnt + 1'b1;

            // Watchdog counts consecutive waits; the flag sets on the same
            // edge that the count reaches TIMEOUT.
            if (w_act == ACT_WAIT) begin
                if (r_wd != WD_W'(TIMEOUT))
                    r_wd <= r_wd + 1'b1;
                if (r_wd >= WD_W'(TIMEOUT - 1))
                    r_imem_err <= 1'b1;
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign bus.id_valid_s1 = r_id_valid;
    assign bus.state_s1    = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
    assign bus.wait_cnt    = r_wait_cnt;
    assign bus.imem_err    = r_imem_err;

endmodule

// File: tb/tb_pipe_if_ctrl.sv
// tb_pipe_if_ctrl
//   Directed self-checking bench for pipe_if_ctrl, built with TIMEOUT=4 and
//   CNT_BITS=4 so watchdog and counter saturation are reachable quickly.
module tb_pipe_if_ctrl;

    localparam int ADDR_LEFT = 4;
    localparam int CNT_BITS  = 4;

    logic clk;
    logic rst_;
    int   n_cmp;
    int   n_err;

    pipe_if_ctrl_if #(.ADDR_LEFT(ADDR_LEFT), .CNT_BITS(CNT_BITS)) bus ();

    pipe_if_ctrl #(
        .CNT_BITS (CNT_BITS),
        .TIMEOUT  (4)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic br, input logic mr,
                         input logic [ADDR_LEFT:0] ert, input logic [ADDR_LEFT:0] rs,
                         input logic [ADDR_LEFT:0] rt, input logic urt);
        bus.imem_valid_s1   = iv;
        bus.branch_taken_s2 = br;
        bus.ex_mem_read     = mr;
        bus.ex_rt           = ert;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rt      = urt;
        #1;
    endtask

    // Combinational controls: pc_en, pc_sel_target, load, flush, bubble.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, bus.pc_en, bus.pc_sel_target, bus.load_instr_s1,
                   bus.flush_s1, bus.bubble_s2}, {27'd0, exp});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_  = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset: FILL outputs even before the first edge.
        check_ctl("rst_ctl_pre", 5'b00111);
        tick();
        check("rst_state", bus.state_s1, 0);
        check("rst_idv", bus.id_valid_s1, 0);
        check("rst_cnts", {bus.stall_cnt, bus.flush_cnt, bus.wait_cnt}, 0);
        check("rst_err", bus.imem_err, 0);
        rst_ = 1'b0;
        #1;

        // Fill then run.
        check_ctl("fill_ctl", 5'b00111);
        tick();
        check("run_state", bus.state_s1, 1);
        check("run_idv0", bus.id_valid_s1, 0);
        check_ctl("run_ctl", 5'b10100);
        tick();
        check("run_idv1", bus.id_valid_s1, 1);
        check("run_cnts", {bus.stall_cnt, bus.flush_cnt, bus.wait_cnt}, 0);

        // Load-use on rs.
        drive(1, 0, 1, 5, 5, 0, 0);
        check_ctl("hz_ctl", 5'b00001);
        tick();
        check("hz_state", bus.state_s1, 3);
        check("hz_cnt", bus.stall_cnt, 1);
        check("hz_idv", bus.id_valid_s1, 1);
        drive(1, 0, 0, 5, 5, 0, 0);
        check_ctl("hz_after_ctl", 5'b10100);
        tick();
        check("hz_after_state", bus.state_s1, 1);

        // ex_rt=0 never stalls; rt only matters when id_uses_rt.
        drive(1, 0, 1, 0, 0, 0, 0);
        check_ctl("hz_r0_ctl", 5'b10100);
        drive(1, 0, 1, 7, 3, 7, 0);
        check_ctl("hz_rt_unused", 5'b10100);
        drive(1, 0, 1, 7, 3, 7, 1);
        check_ctl("hz_rt_used", 5'b00001);
        tick();
        check("hz_rt_cnt", bus.stall_cnt, 2);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        // Taken branch with a valid ID instruction.
        drive(1, 1, 0, 0, 0, 0, 0);
        check_ctl("br_ctl", 5'b11110);
        tick();
        check("br_state", bus.state_s1, 4);
        check("br_idv", bus.id_valid_s1, 0);
        check("br_cnt", bus.flush_cnt, 1);
        // Branch signal with id_valid=0 is ignored.
        check_ctl("br_inv_ctl", 5'b10100);
        tick();
        check("br_inv_state", bus.state_s1, 1);
        check("br_inv_cnt", bus.flush_cnt, 1);

        // Hazard and branch together: stall first, redirect next.
        drive(1, 1, 1, 5, 5, 0, 0);
        check_ctl("hzbr_ctl1", 5'b00001);
        tick();
        check("hzbr_stall", bus.stall_cnt, 3);
        drive(1, 1, 0, 5, 5, 0, 0);
        check_ctl("hzbr_ctl2", 5'b11110);
        tick();
        check("hzbr_flush", bus.flush_cnt, 2);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        // Branch while imem not valid: redirect still happens.
        drive(0, 1, 0, 0, 0, 0, 0);
        check_ctl("brw_ctl", 5'b11110);
        tick();
        check("brw_state", bus.state_s1, 4);
        check("brw_cnts", {bus.flush_cnt, bus.wait_cnt}, {4'd3, 4'd0});

        // Three wait cycles.
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ctl("wait_ctl", 5'b00110);
        tick();
        tick();
        tick();
        check("wait_state", bus.state_s1, 2);
        check("wait_cnt3", bus.wait_cnt, 3);
        check("wait_err0", bus.imem_err, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("wait_end_state", bus.state_s1, 1);

        // Watchdog: six waits, flag sets on the 4th wait edge and sticks.
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        check("wd_err_3", bus.imem_err, 0);
        tick();
        check("wd_err_4", bus.imem_err, 1);
        tick();
        tick();
        check("wd_wait_cnt", bus.wait_cnt, 9);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("wd_err_sticky", bus.imem_err, 1);

        // Counter saturation at 15.
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        check("sat_15", bus.wait_cnt, 15);
        tick();
        tick();
        check("sat_hold", bus.wait_cnt, 15);

        // Reset mid-wait clears everything.
        rst_ = 1'b1;
        #1;
        check_ctl("rst2_ctl", 5'b00111);
        tick();
        check("rst2_state", bus.state_s1, 0);
        check("rst2_err", bus.imem_err, 0);
        check("rst2_cnts", {bus.stall_cnt, bus.flush_cnt, bus.wait_cnt}, 0);
        check("rst2_idv", bus.id_valid_s1, 0);
        rst_ = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        check_ctl("rst2_fill", 5'b00111);
        tick();
        check_ctl("rst2_run", 5'b10100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
